spi_rx_buf: RTL and testbench
=============================

# spi_rx_buf

SPI receive buffer: deserialises the serial data line into parallel words on rising `sck` edges, complementing the transmit buffer, which drives data on falling edges. It sits on the slave side of the SPI-to-SRAM interface, between the serial input pin and the command/address/data decode logic. A completed word is presented with a valid/acknowledge handshake. Overrun detection is optional.

## Interface
- `WIDTH`, default 8: word length in bits; legal range 2..15.
- `sck` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `sdi` input 1: serial data in, sampled on the rising `sck` edge.
- `ShiftRx` input 1: frame enable (chip-select qualified); sampling occurs only while high.
- `RxAck` input 1: consumer acknowledge of the current word.
- `ParallelOut` output WIDTH: last completed word, MSB first on the wire.
- `RxValid` output 1: `ParallelOut` holds an unacknowledged word.
- `RxCount` output 4: bits captured in the current partial word, 0..WIDTH-1.
- `Overrun` output 1: sticky error flag (see Configuration).

## Operation
- Internal shift register `sr[WIDTH-1:0]`; bits enter at the LSB: `sr <= {sr[WIDTH-2:0], sdi}`.
- Rising edge with `ShiftRx=1` and `RxCount < WIDTH-1`:
  - shift `sdi` into `sr`;
  - `RxCount` increments by 1.
- Rising edge with `ShiftRx=1` and `RxCount == WIDTH-1` (word completion):
  - the completed word is `{sr[WIDTH-2:0], sdi}`;
  - `RxCount` wraps to 0;
  - the word is delivered per the handshake rules below.
- Rising edge with `ShiftRx=0`:
  - `RxCount` is cleared to 0 and partial bits are discarded (frame abort);
  - `sr` is not cleared; stale bits are never delivered because the count restarts;
  - `RxValid`, `ParallelOut` and `Overrun` are unaffected except by `RxAck`.
- Handshake:
  - A rising edge with `RxAck=1` clears `RxValid`, and clears `Overrun` when the macro is enabled.
  - `RxAck` while `RxValid=0` has no effect.
- Completion with `RxValid=0`: `ParallelOut` loads the word and `RxValid` is set.
- Completion on the same edge as `RxAck=1`:
  - the new word is loaded;
  - `RxValid` remains 1;
  - `Overrun` is not set; the ack retires the old word.
- Completion with `RxValid=1` and `RxAck=0`: handled per Configuration.

## Timing
- Reset values: `ParallelOut=0`, `RxValid=0`, `RxCount=0`, `Overrun=0`, `sr=0`.
- Reset mid-word discards the partial word. The first edge after reset release with `ShiftRx=1` captures bit WIDTH-1 of a new word.
- Latency: `RxValid` rises after the rising edge that samples the final (LSB) bit of a word. It is registered and requires no extra cycle.
- Back-to-back words with no gap are supported: the first bit of the next word is sampled on the edge immediately after completion.
- `RxAck` is sampled on rising `sck` only. The consumer must drive it synchronous to `sck`, and `RxValid` falls one edge after `RxAck` is seen.
- All outputs are registers; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SPI_RX_OVERRUN_EN`.
- Defined: a completion while `RxValid=1` and `RxAck=0`:
  - drops the new word;
  - holds `ParallelOut` and `RxValid=1`;
  - sets `Overrun=1`.
  - `Overrun` stays high until a rising edge with `RxAck=1`, or until reset.
- Undefined: the same event overwrites `ParallelOut` with the new word and keeps `RxValid=1`. `Overrun` is a constant 0 and its logic is not generated.

## Test plan
- **Reset:** assert `rst` asynchronously mid-word, after 3 bits. Required: all outputs go to 0 immediately. After release, shift `0xA5` MSB first; required: `ParallelOut=0xA5` and `RxValid=1` after the 8th edge.
- **Back-to-back words:** shift `0x3C` then `0xC3` with no gap, and assert `RxAck` on the edge that completes `0xC3`. Required: `ParallelOut=0xC3`, `RxValid=1`, `Overrun=0`.
- **Frame abort:** shift 5 bits of `0xFF`, drop `ShiftRx` for one edge, then shift `0x12`. Required: `RxCount` reads 0 after the abort, and the delivered word is `0x12`, not a mix of the two.
- **Overrun, macro defined:** shift `0x55` and `0xAA` with no ack. Required: `ParallelOut=0x55`, `Overrun=1`. Then assert `RxAck`; required: `RxValid=0`, `Overrun=0`.
- **Overrun, macro undefined:** same stimulus as the previous scenario. Required: `ParallelOut=0xAA`, `RxValid=1`, `Overrun=0` throughout.
- **Count tracking:** check `RxCount` after every edge across a full word. Required: the sequence 1,2,…,7,0, with `RxValid` rising exactly as `RxCount` wraps to 0.

Source files
------------

// File: rtl/spi_rx_buf.sv
// SPI receive buffer: shifts sdi in MSB first on rising sck and presents each word with a valid/ack handshake.
// Optional overrun detection is enabled by defining SPI_RX_OVERRUN_EN.
module spi_rx_buf #(
  parameter int WIDTH = 8
) (
  input  logic             sck,
  input  logic             rst,
  input  logic             sdi,
  input  logic             ShiftRx,
  input  logic             RxAck,
  output logic [WIDTH-1:0] ParallelOut,
  output logic             RxValid,
  output logic [3:0]       RxCount,
  output logic             Overrun
);

  localparam logic [3:0] LAST = 4'(WIDTH - 1);

  // The oldest shift bit is always pushed out before a word completes, so only WIDTH-1 bits are held.
  logic [WIDTH-2:0] sr_reg, sr_next;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] out_reg, out_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             valid_reg, valid_next;
  logic             complete, take;

  always_comb begin
    word     = {sr_reg, sdi};
    complete = ShiftRx && (cnt_reg == LAST);
`ifdef SPI_RX_OVERRUN_EN
    // A pending, unacknowledged word wins; the new word is dropped.
    take     = complete && (!valid_reg || RxAck);
`else
    take     = complete;
`endif
    sr_next    = ShiftRx ? word[WIDTH-2:0] : sr_reg;
    cnt_next   = (ShiftRx && !complete) ? cnt_reg + 4'd1 : 4'd0;
    out_next   = take ? word : out_reg;
    valid_next = take || (valid_reg && !RxAck);
  end

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      sr_reg    <= '0;
      cnt_reg   <= 4'd0;
      out_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      sr_reg    <= sr_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      valid_reg <= valid_next;
    end
  end

`ifdef SPI_RX_OVERRUN_EN
  logic ovr_reg, ovr_next;

  always_comb begin
    ovr_next = (complete && valid_reg && !RxAck) || (ovr_reg && !RxAck);
  end

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      ovr_reg <= 1'b0;
    end else begin
      ovr_reg <= ovr_next;
    end
  end

  assign Overrun = ovr_reg;
`else
  assign Overrun = 1'b0;
`endif

  assign ParallelOut = out_reg;
  assign RxValid     = valid_reg;
  assign RxCount     = cnt_reg;

endmodule

// File: tb/tb_spi_rx_buf.sv
// Scoreboard bench for spi_rx_buf: the driver queues hand-computed expected outputs per sck edge,
// and a monitor compares them on the following falling edge.
module tb_spi_rx_buf;

  logic       sck = 1'b0;
  logic       rst;
  logic       sdi;
  logic       ShiftRx;
  logic       RxAck;
  logic [7:0] ParallelOut;
  logic       RxValid;
  logic [3:0] RxCount;
  logic       Overrun;

  typedef struct {
    logic [7:0] po;
    logic       v;
    logic [3:0] cnt;
    logic       ov;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  always #5 sck = ~sck;

  spi_rx_buf #(.WIDTH(8)) dut (
    .sck        (sck),
    .rst        (rst),
    .sdi        (sdi),
    .ShiftRx    (ShiftRx),
    .RxAck      (RxAck),
    .ParallelOut(ParallelOut),
    .RxValid    (RxValid),
    .RxCount    (RxCount),
    .Overrun    (Overrun)
  );

  task automatic check(input string name, input logic [7:0] po, input logic v,
                       input logic [3:0] cnt, input logic ov);
    checks++;
    if (ParallelOut === po && RxValid === v && RxCount === cnt && Overrun === ov) begin
      passes++;
      $display("check %s: po=%h v=%b cnt=%0d ov=%b ok", name, ParallelOut, RxValid, RxCount, Overrun);
    end else begin
      $display("FAIL %s: got po=%h v=%b cnt=%0d ov=%b, expected po=%h v=%b cnt=%0d ov=%b",
               name, ParallelOut, RxValid, RxCount, Overrun, po, v, cnt, ov);
    end
  endtask

  // Monitor: one expectation per driven rising edge, compared on the next falling edge.
  always @(negedge sck) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check(e.name, e.po, e.v, e.cnt, e.ov);
    end
  end

  task automatic step(input logic d, input logic sh, input logic ack, input logic [7:0] po,
                      input logic v, input logic [3:0] cnt, input logic ov, input string name);
    exp_t e;
    @(negedge sck);
    #1;
    sdi     = d;
    ShiftRx = sh;
    RxAck   = ack;
    e.po = po; e.v = v; e.cnt = cnt; e.ov = ov; e.name = name;
    q.push_back(e);
  endtask

  // Shifts a byte MSB first; h* is the state held during bits 7..1, e* the state after the final bit.
  task automatic send_word(input logic [7:0] w, input logic ack_last,
                           input logic [7:0] hpo, input logic hv, input logic hov,
                           input logic [7:0] epo, input logic ev, input logic eov,
                           input string name);
    for (int i = 0; i < 7; i++)
      step(w[7-i], 1'b1, 1'b0, hpo, hv, 4'(i + 1), hov, name);
    step(w[0], 1'b1, ack_last, epo, ev, 4'd0, eov, name);
  endtask

  initial begin
    rst = 1'b1; sdi = 1'b0; ShiftRx = 1'b0; RxAck = 1'b0;
    #1;
    check("reset_state", 8'h00, 1'b0, 4'd0, 1'b0);
    @(negedge sck);
    #1 rst = 1'b0;

    // Back-to-back words, ack on the edge completing the second.
    send_word(8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, "b2b_3c");
    send_word(8'hC3, 1'b1, 8'h3C, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, "b2b_c3_ack");
    step(1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 4'd0, 1'b0, "ack_c3");

    // Asynchronous reset after three bits of a word.
    step(1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 4'd1, 1'b0, "pre_reset");
    step(1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 4'd2, 1'b0, "pre_reset");
    step(1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 4'd3, 1'b0, "pre_reset");
    @(negedge sck);
    ShiftRx = 1'b0; RxAck = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_reset", 8'h00, 1'b0, 4'd0, 1'b0);
    @(negedge sck);
    #1 rst = 1'b0;
    send_word(8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, "after_reset_a5");
    step(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd0, 1'b0, "ack_a5");

    // Frame abort after five bits of 0xFF.
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 4'(i + 1), 1'b0, "partial_ff");
    step(1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0, 1'b0, "abort");
    send_word(8'h12, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, "after_abort_12");
    step(1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 4'd0, 1'b0, "ack_12");
    step(1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 4'd0, 1'b0, "ack_when_idle");

    // Two words without an ack in between.
    send_word(8'h55, 1'b0, 8'h12, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, "ovr_55");
`ifdef SPI_RX_OVERRUN_EN
    send_word(8'hAA, 1'b0, 8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1, "ovr_aa_dropped");
    step(1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 4'd0, 1'b1, "ovr_sticky");
    step(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 4'd0, 1'b0, "ovr_ack");
`else
    send_word(8'hAA, 1'b0, 8'h55, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, "ovr_aa_overwrite");
    step(1'b0, 1'b0, 1'b0, 8'hAA, 1'b1, 4'd0, 1'b0, "ovr_hold");
    step(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 4'd0, 1'b0, "ovr_ack");
`endif

    @(negedge sck);
    ShiftRx = 1'b0; RxAck = 1'b0;
    for (int k = 0; k < 4 && q.size() > 0; k++)
      @(posedge sck);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
